// File: rtl/lsb_mem_unit.sv
// Byte-serial data memory access unit sitting between the load/store buffer and the 8-bit RAM/IO bus.
// Optional build macro MISALIGN_CHECK_EN adds misalign_fault and traps misaligned H/W accesses.
module lsb_mem_unit #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000,
    parameter logic [6:0]  LD_TYPE = 7'b0000011
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic        lsb_visit_mem,
    input  logic [6:0]  op_type_in,
    input  logic [2:0]  op_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_val_in,
    output logic        cache_welcome_signal,
    output logic        cache_ready,
    output logic        is_load,
    output logic [31:0] load_val_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
`ifdef MISALIGN_CHECK_EN
    output logic        misalign_fault,
`endif
    output logic [1:0]  o_dbg_state
);

    // Handshake: a request is taken on a clock edge where lsb_visit_mem, cache_welcome_signal
    // and rdy_in are all high; completion is the one-cycle cache_ready pulse.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [2:0]  r_op, w_op_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic [23:0] r_buf, w_buf_nxt;
    logic        r_flushed, w_flushed_nxt;
    logic        r_cache_ready, w_cache_ready_nxt;
    logic        r_is_load, w_is_load_nxt;
    logic [31:0] r_load_val, w_load_val_nxt;
    logic [7:0]  r_mem_dout, w_mem_dout_nxt;
    logic [31:0] r_mem_a, w_mem_a_nxt;
    logic        r_mem_wr, w_mem_wr_nxt;

    logic        w_accept;
    logic        w_acc_load;
    logic        w_misalign;
    logic [2:0]  w_cnt_inc;
    logic        w_last;
    logic [31:0] w_next_addr;
    logic [31:0] w_ext;

    function automatic logic [2:0] size_of(input logic [1:0] sz);
        case (sz)
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] k);
        case (k)
            2'd0:    byte_of = d[7:0];
            2'd1:    byte_of = d[15:8];
            2'd2:    byte_of = d[23:16];
            default: byte_of = d[31:24];
        endcase
    endfunction

    function automatic logic io_stall(input logic [31:0] a, input logic full);
        io_stall = (a >= IO_BASE) && full;
    endfunction

    assign w_accept    = (r_state == ST_IDLE) && lsb_visit_mem && !rob_clear_up;
    assign w_acc_load  = (op_type_in == LD_TYPE);
    assign w_cnt_inc   = r_cnt + 3'd1;
    assign w_last      = (w_cnt_inc == size_of(r_op[1:0]));
    assign w_next_addr = r_addr + {29'd0, w_cnt_inc};

`ifdef MISALIGN_CHECK_EN
    assign w_misalign = ((op_in[1:0] == 2'b01) && addr_in[0]) ||
                        (op_in[1] && (addr_in[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // The final byte comes straight from the bus so the result is ready on the last edge.
    always_comb begin
        w_ext = 32'd0;
        case (r_op[1:0])
            2'b00:   w_ext = {{24{mem_din[7] & ~r_op[2]}}, mem_din};
            2'b01:   w_ext = {{16{mem_din[7] & ~r_op[2]}}, mem_din, r_buf[7:0]};
            default: w_ext = {mem_din, r_buf[23:0]};
        endcase
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_op_nxt          = r_op;
        w_addr_nxt        = r_addr;
        w_data_nxt        = r_data;
        w_buf_nxt         = r_buf;
        w_flushed_nxt     = r_flushed;
        w_cache_ready_nxt = 1'b0;
        w_is_load_nxt     = 1'b0;
        w_load_val_nxt    = r_load_val;
        w_mem_dout_nxt    = r_mem_dout;
        w_mem_a_nxt       = r_mem_a;
        w_mem_wr_nxt      = r_mem_wr;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_op_nxt      = op_in;
                    w_addr_nxt    = addr_in;
                    w_data_nxt    = store_val_in;
                    w_cnt_nxt     = 3'd0;
                    w_flushed_nxt = 1'b0;
                    if (w_misalign) begin
                        w_cache_ready_nxt = 1'b1;
                        w_is_load_nxt     = w_acc_load;
                        w_load_val_nxt    = 32'd0;
                        w_mem_wr_nxt      = 1'b0;
                    end else if (w_acc_load) begin
                        w_state_nxt  = ST_LOAD;
                        w_mem_a_nxt  = addr_in;
                        w_mem_wr_nxt = 1'b0;
                    end else begin
                        w_state_nxt    = ST_STORE;
                        w_mem_a_nxt    = addr_in;
                        w_mem_dout_nxt = store_val_in[7:0];
                        w_mem_wr_nxt   = !io_stall(addr_in, io_buffer_full);
                    end
                end
            end
            ST_LOAD: begin
                if (rob_clear_up) begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = 3'd0;
                    w_mem_a_nxt  = 32'd0;
                    w_mem_wr_nxt = 1'b0;
                end else if (w_last) begin
                    w_state_nxt       = ST_IDLE;
                    w_cnt_nxt         = 3'd0;
                    w_mem_a_nxt       = 32'd0;
                    w_load_val_nxt    = w_ext;
                    w_is_load_nxt     = 1'b1;
                    w_cache_ready_nxt = 1'b1;
                end else begin
                    case (r_cnt[1:0])
                        2'd0:    w_buf_nxt[7:0]   = mem_din;
                        2'd1:    w_buf_nxt[15:8]  = mem_din;
                        default: w_buf_nxt[23:16] = mem_din;
                    endcase
                    w_cnt_nxt   = w_cnt_inc;
                    w_mem_a_nxt = w_next_addr;
                end
            end
            ST_STORE: begin
                // A flushed store is already committed: it completes silently.
                w_flushed_nxt = r_flushed | rob_clear_up;
                if (r_mem_wr) begin
                    if (w_last) begin
                        w_state_nxt       = ST_IDLE;
                        w_cnt_nxt         = 3'd0;
                        w_mem_a_nxt       = 32'd0;
                        w_mem_wr_nxt      = 1'b0;
                        w_load_val_nxt    = 32'd0;
                        w_cache_ready_nxt = !(r_flushed | rob_clear_up);
                    end else begin
                        w_cnt_nxt      = w_cnt_inc;
                        w_mem_a_nxt    = w_next_addr;
                        w_mem_dout_nxt = byte_of(r_data, w_cnt_inc[1:0]);
                        w_mem_wr_nxt   = !io_stall(w_next_addr, io_buffer_full);
                    end
                end else begin
                    w_mem_wr_nxt = !io_stall(r_mem_a, io_buffer_full);
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_mem_wr_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 3'd0;
            r_op          <= 3'd0;
            r_addr        <= 32'd0;
            r_data        <= 32'd0;
            r_buf         <= 24'd0;
            r_flushed     <= 1'b0;
            r_cache_ready <= 1'b0;
            r_is_load     <= 1'b0;
            r_load_val    <= 32'd0;
            r_mem_dout    <= 8'd0;
            r_mem_a       <= 32'd0;
            r_mem_wr      <= 1'b0;
        end else if (rdy_in) begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_op          <= w_op_nxt;
            r_addr        <= w_addr_nxt;
            r_data        <= w_data_nxt;
            r_buf         <= w_buf_nxt;
            r_flushed     <= w_flushed_nxt;
            r_cache_ready <= w_cache_ready_nxt;
            r_is_load     <= w_is_load_nxt;
            r_load_val    <= w_load_val_nxt;
            r_mem_dout    <= w_mem_dout_nxt;
            r_mem_a       <= w_mem_a_nxt;
            r_mem_wr      <= w_mem_wr_nxt;
        end
    end

`ifdef MISALIGN_CHECK_EN
    logic r_fault;
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_fault <= 1'b0;
        end else if (rdy_in) begin
            r_fault <= w_accept && w_misalign;
        end
    end
    assign misalign_fault = r_fault;
`endif

    // Write strobe is masked while frozen so a held byte is never written twice.
    assign mem_wr               = r_mem_wr & rdy_in;
    assign cache_welcome_signal = (r_state == ST_IDLE) && !rob_clear_up;
    assign cache_ready          = r_cache_ready;
    assign is_load              = r_is_load;
    assign load_val_out         = r_load_val;
    assign mem_dout             = r_mem_dout;
    assign mem_a                = r_mem_a;
    assign o_dbg_state          = r_state;

endmodule

// File: doc/lsb_mem_unit.md
Name: lsb_mem_unit

Overview:
- Data-side memory access unit directly downstream of the load/store buffer.
- Accepts one load or store request at a time from the LSB.
- Runs it byte-serially on the 8-bit RAM/IO bus, sign- or zero-extends load data, and returns a one-cycle completion pulse the LSB and RS broadcast network consume.
- Honours pipeline flush and IO back-pressure.

Parameters:
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are IO-mapped; stores there obey io_buffer_full.
- LD_TYPE, 7'b0000011, opcode value meaning load; any other op_type is treated as store.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low (asserted when 0).
- rdy_in  input  1  global ready; when 0, all state and outputs hold.
- rob_clear_up  input  1  flush from ROB.
- lsb_visit_mem  input  1  request valid (level) from LSB.
- op_type_in  input  7  opcode of request.
- op_in  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_in  input  32  effective address.
- store_val_in  input  32  store data; the low bytes are used.
- cache_welcome_signal  output  1  unit idle, request may be sampled this edge.
- cache_ready  output  1  one-cycle completion pulse.
- is_load  output  1  completed access was a load (valid with cache_ready).
- load_val_out  output  32  extended load result (valid with cache_ready).
- mem_din  input  8  RAM read byte, valid one cycle after address.
- mem_dout  output  8  RAM write byte.
- mem_a  output  32  RAM byte address.
- mem_wr  output  1  1 = write, 0 = read.
- io_buffer_full  input  1  IO write buffer full.

Behaviour:
- Reset (rst_in=0, async): state IDLE; cache_ready=0, is_load=0, load_val_out=0, mem_dout=0, mem_a=0, mem_wr=0, byte counter=0.
- States: IDLE, LOAD, STORE.
- cache_welcome_signal = (state==IDLE) && !rob_clear_up; combinational.
- Access size N: 1 for op[1:0]=00, 2 for 01, 4 for 10. Byte k uses address addr_in+k with 32-bit wrap.
- Accept edge E0 (IDLE, visit, welcome, rdy_in):
  - Latch op_type, op, address and data.
  - Load: mem_a=addr, mem_wr=0, go to LOAD.
  - Store: mem_a=addr, mem_dout=byte0, mem_wr=1, go to STORE. Exception: if IO address and io_buffer_full, mem_wr=0 and byte0 is retried each cycle until not full.
- LOAD: at edge E_k (k=1..N), sample mem_din as byte k-1 and drive mem_a=addr+k. At E_N:
  - Assemble little-endian and extend (sign-extend for B/H, zero-extend for BU/HU).
  - Set load_val_out, is_load=1, cache_ready=1; return to IDLE; mem_a=0.
  - Latency: cache_ready is high in the cycle after E_N. LW sees ready after E4, LB after E1.
- STORE: each edge that writes byte k advances to byte k+1. After the last byte is written: mem_wr=0, cache_ready=1, is_load=0, load_val_out=0, go to IDLE.
  - IO stall at any byte: mem_wr=0, counter holds.
  - Non-IO stores never stall; SW ready comes after E4.
- cache_ready and is_load are high for exactly one cycle, then cleared.
- rob_clear_up during LOAD: abort immediately; IDLE, mem_wr=0, no cache_ready pulse.
- rob_clear_up during STORE: the store finishes writing all bytes (it is already committed), but its cache_ready pulse is suppressed.
- rob_clear_up in IDLE: no request is accepted that edge.
- rdy_in=0: freeze everything, including the counter. mem_wr is forced 0 while frozen so no byte is duplicated; the pending byte is re-driven when rdy_in returns.
- A request present while busy is ignored (the LSB holds it).

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined: extra output misalign_fault (1 bit). H/HU with addr[0]=1 or W with addr[1:0]!=0 does no bus activity. In the cycle after accept it gives cache_ready=1, misalign_fault=1, load_val_out=0, then IDLE. misalign_fault resets to 0 and is 0 on normal completions.
- Undefined: no port; misaligned accesses run byte-serially like any other.

Test Plan:
- LW at 0x100, RAM bytes 0x78,0x56,0x34,0x12 -> cache_ready after E4, load_val_out=0x12345678, is_load=1, mem_wr always 0.
- LB at 0x200, byte 0x80 -> 0xFFFFFF80 after E1; LBU same address -> 0x00000080.
- SH 0xABCD to 0x300 -> mem_wr=1 with (0x300,0xCD) then (0x301,0xAB), ready one cycle, is_load=0.
- SB 0x41 to 0x30000 with io_buffer_full high 3 cycles -> no write for 3 cycles, then one write, then ready.
- LW accepted, rob_clear_up at E2 -> no cache_ready, welcome high next cycle. Same flush during SW -> all 4 bytes written, no ready pulse.
- With MISALIGN_CHECK_EN, LW at 0x102 -> misalign_fault=1 and cache_ready next cycle, no mem_wr.
